ram_bank: RTL and testbench

RAM_BANK -- requirements
Module: ram_bank

---
 rtl/ram_bank_pkg.sv | 19 +
 rtl/ram_bank_array.sv | 64 ++++++
 rtl/ram_bank.sv | 129 ++++++++++++
 tb/tb_ram_bank.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ram_bank_pkg.sv
// Shared types and defaults for the ram_bank block: FSM state encoding,
// default geometry and the byte-parity helper used by the optional
// parity storage (enabled with RAM_BANK_PARITY_EN).
package ram_bank_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 10;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    // Even parity bit of one byte: 1 when the byte holds an odd number of ones.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/ram_bank_array.sv
// Word-addressed storage with per-byte write enables and an asynchronous
// read port. Contents carry no reset; they are zeroed by the owner's sweep.
// With RAM_BANK_PARITY_EN defined, one even-parity bit per byte is stored
// alongside the data and checked on the read port.
module ram_bank_array
    import ram_bank_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wbe,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [DATA_W-1:0]   rdata,
    output logic                rpar_err
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Byte-masked data write.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[raddr];

`ifdef RAM_BANK_PARITY_EN
    logic [NB-1:0] par_q [DEPTH];

    // Parity bits follow their bytes on every enabled byte write.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    par_q[waddr][i] <= byte_parity(wdata[8*i +: 8]);
                end
            end
        end
    end

    // Flag any byte whose recomputed parity differs from the stored bit.
    always_comb begin
        rpar_err = 1'b0;
        for (int i = 0; i < NB; i++) begin
            rpar_err = rpar_err | (par_q[raddr][i] ^ byte_parity(rdata[8*i +: 8]));
        end
    end
`else
    assign rpar_err = 1'b0;
`endif

endmodule

// File: rtl/ram_bank.sv
// Single-port RAM bank with a clear sweep. After reset (or a clear request)
// the bank zeroes every word, one per cycle, while busy is high; afterwards
// it accepts one read or byte-masked write per cycle. Reads have one cycle
// of latency and hold data_out until the next read.
// Optional feature macro: RAM_BANK_PARITY_EN (per-byte parity, parity_err).
module ram_bank
    import ram_bank_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic                rw,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [DATA_W/8-1:0] byte_en,
    input  logic                clear,
    output logic [DATA_W-1:0]   data_out,
    output logic                rvalid,
    output logic                busy,
    output logic                parity_err
);

    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                rvalid_q, rvalid_d;
    logic                busy_q, busy_d;
    logic                parity_err_q, parity_err_d;

    logic                we_s;
    logic [ADDR_W-1:0]   waddr_s;
    logic [DATA_W-1:0]   wdata_s;
    logic [NB-1:0]       wbe_s;
    logic [DATA_W-1:0]   rdata_s;
    logic                rpar_err_s;

    ram_bank_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk      (clk),
        .we       (we_s),
        .waddr    (waddr_s),
        .wdata    (wdata_s),
        .wbe      (wbe_s),
        .raddr    (address),
        .rdata    (rdata_s),
        .rpar_err (rpar_err_s)
    );

    // Next-state, sweep counter, array write port and output register inputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        data_out_d   = data_out_q;
        rvalid_d     = 1'b0;
        parity_err_d = 1'b0;
        we_s         = 1'b0;
        waddr_s      = address;
        wdata_s      = data_in;
        wbe_s        = byte_en;
        case (state_q)
            S_CLEAR: begin
                // Sweep owns the write port; req and clear are ignored here.
                we_s    = 1'b1;
                waddr_s = cnt_q;
                wdata_s = {DATA_W{1'b0}};
                wbe_s   = {NB{1'b1}};
                if (cnt_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                    cnt_d   = {ADDR_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            S_IDLE: begin
                if (clear) begin
                    // Clear wins over a same-cycle access, which is dropped.
                    state_d = S_CLEAR;
                    cnt_d   = {ADDR_W{1'b0}};
                end else if (req && rw) begin
                    data_out_d   = rdata_s;
                    rvalid_d     = 1'b1;
                    parity_err_d = rpar_err_s;
                end else if (req) begin
                    we_s = 1'b1;
                end else begin
                    we_s = 1'b0;
                end
            end
            default: begin
                state_d = S_CLEAR;
                cnt_d   = {ADDR_W{1'b0}};
            end
        endcase
        busy_d = (state_d == S_CLEAR);
    end

    // State and output registers; reset restarts the sweep from address 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_CLEAR;
            cnt_q        <= {ADDR_W{1'b0}};
            data_out_q   <= {DATA_W{1'b0}};
            rvalid_q     <= 1'b0;
            busy_q       <= 1'b1;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            data_out_q   <= data_out_d;
            rvalid_q     <= rvalid_d;
            busy_q       <= busy_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign data_out   = data_out_q;
    assign rvalid     = rvalid_q;
    assign busy       = busy_q;
    assign parity_err = parity_err_q;

endmodule

// File: tb/tb_ram_bank.sv
// Directed self-checking bench for ram_bank (DATA_W=16, ADDR_W=10).
module tb_ram_bank;

    logic        clk;
    logic        reset;
    logic        req;
    logic        rw;
    logic [9:0]  address;
    logic [15:0] data_in;
    logic [1:0]  byte_en;
    logic        clear;
    logic [15:0] data_out;
    logic        rvalid;
    logic        busy;
    logic        parity_err;

    int checks   = 0;
    int failures = 0;

    ram_bank #(.DATA_W(16), .ADDR_W(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .rw         (rw),
        .address    (address),
        .data_in    (data_in),
        .byte_en    (byte_en),
        .clear      (clear),
        .data_out   (data_out),
        .rvalid     (rvalid),
        .busy       (busy),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [9:0] a, input logic [15:0] d, input logic [1:0] be);
        req = 1'b1; rw = 1'b0; address = a; data_in = d; byte_en = be;
        tick();
        req = 1'b0;
    endtask

    task automatic do_read(input logic [9:0] a);
        req = 1'b1; rw = 1'b1; address = a;
        tick();
        req = 1'b0;
    endtask

    // Counts edges until busy drops, bounded so a stuck sweep still ends.
    task automatic count_busy(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < 2000);
    endtask

    int  n;
    logic saw_rvalid;

    initial begin
        reset = 1'b1; req = 1'b0; rw = 1'b0; address = 10'h000;
        data_in = 16'h0000; byte_en = 2'b00; clear = 1'b0;
        tick();
        tick();
        chk("rst_busy",   {31'd0, busy},       32'd1);
        chk("rst_rvalid", {31'd0, rvalid},     32'd0);
        chk("rst_dout",   {16'd0, data_out},   32'h0);
        chk("rst_perr",   {31'd0, parity_err}, 32'd0);

        // Sweep length after reset release.
        reset = 1'b0;
        count_busy(n);
        chk("sweep_len", n, 32'd1024);
        do_read(10'h3FF);
        chk("rd_3ff_data",   {16'd0, data_out}, 32'h0000);
        chk("rd_3ff_rvalid", {31'd0, rvalid},   32'd1);
        tick();
        chk("rvalid_pulse",  {31'd0, rvalid},   32'd0);

        // Back-to-back reads after two writes.
        do_write(10'h000, 16'h0005, 2'b11);
        do_write(10'h001, 16'h0009, 2'b11);
        do_read(10'h000);
        chk("b2b_rd0_data",   {16'd0, data_out}, 32'h0005);
        chk("b2b_rd0_rvalid", {31'd0, rvalid},   32'd1);
        do_read(10'h001);
        chk("b2b_rd1_data",   {16'd0, data_out}, 32'h0009);
        chk("b2b_rd1_rvalid", {31'd0, rvalid},   32'd1);
        chk("rd_perr",        {31'd0, parity_err}, 32'd0);
        do_write(10'h001, 16'h1111, 2'b11);
        chk("wr_holds_dout",  {16'd0, data_out}, 32'h0009);
        chk("wr_no_rvalid",   {31'd0, rvalid},   32'd0);

        // Byte-enable writes; read right after write sees the new data.
        do_write(10'h002, 16'hABCD, 2'b11);
        do_write(10'h002, 16'h1234, 2'b01);
        do_read(10'h002);
        chk("be01_merge", {16'd0, data_out}, 32'hAB34);
        do_write(10'h002, 16'h5678, 2'b00);
        do_read(10'h002);
        chk("be00_noop",  {16'd0, data_out}, 32'hAB34);
        do_write(10'h002, 16'h9900, 2'b10);
        do_read(10'h002);
        chk("be10_merge", {16'd0, data_out}, 32'h9934);

        // Reset in the middle of an access aborts it immediately.
        req = 1'b1; rw = 1'b1; address = 10'h002;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy},     32'd1);
        chk("mid_rst_dout", {16'd0, data_out}, 32'h0);
        req = 1'b0;
        tick();
        reset = 1'b0;
        // Abort the sweep at counter 500, then check a full restart.
        for (int i = 0; i < 500; i++) tick();
        chk("busy_at_500", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_busy(n);
        chk("restart_len", n, 32'd1024);
        do_read(10'h001);
        chk("rst_zeroed_a1", {16'd0, data_out}, 32'h0000);
        do_read(10'h002);
        chk("rst_zeroed_a2", {16'd0, data_out}, 32'h0000);

        // Clear beats a same-cycle write; clear and req during sweep ignored.
        do_write(10'h003, 16'h4242, 2'b11);
        clear = 1'b1; req = 1'b1; rw = 1'b0; address = 10'h003;
        data_in = 16'h7777; byte_en = 2'b11;
        tick();
        clear = 1'b0; req = 1'b0;
        chk("clear_busy", {31'd0, busy}, 32'd1);
        saw_rvalid = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
            if (rvalid) saw_rvalid = 1'b1;
            if (n == 100) clear = 1'b1;
            if (n == 101) clear = 1'b0;
            if (n == 200) begin
                req = 1'b1; rw = 1'b0; address = 10'h005; data_in = 16'hFFFF;
            end
            if (n == 201) begin
                req = 1'b1; rw = 1'b1; address = 10'h005;
            end
            if (n == 202) req = 1'b0;
        end while (busy && n < 2000);
        chk("clear_len",       n, 32'd1024);
        chk("sweep_no_rvalid", {31'd0, saw_rvalid}, 32'd0);
        do_read(10'h003);
        chk("clear_drop_a3", {16'd0, data_out}, 32'h0000);
        do_read(10'h005);
        chk("sweep_no_wr_a5", {16'd0, data_out}, 32'h0000);

`ifdef RAM_BANK_PARITY_EN
        do_write(10'h004, 16'h00FF, 2'b11);
        do_write(10'h006, 16'h0F0F, 2'b11);
        dut.u_array.mem_q[4] = dut.u_array.mem_q[4] ^ 16'h0001;
        do_read(10'h004);
        chk("par_flip_err",    {31'd0, parity_err}, 32'd1);
        chk("par_flip_rvalid", {31'd0, rvalid},     32'd1);
        do_read(10'h006);
        chk("par_ok_err",      {31'd0, parity_err}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
